// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry controller: key codes, FSM encoding
// and the millisecond-to-clock-tick conversion.
package keypad_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;  // enter / commit
  localparam logic [3:0] KEY_F = 4'hF;  // clear

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } kp_state_e;

  function automatic int ms_to_ticks(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Release timer and press FSM: turns raw scanner samples into one registered
// key_event pulse per physical press, with the accepted code in key_code.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int RELEASE_MS  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] kp_key,
  input  logic       kp_pressed,
  output logic       key_event,
  output logic [3:0] key_code
);

  localparam int DEB_T = ms_to_ticks(CLK_HZ, DEBOUNCE_MS);
  localparam int REL_T = ms_to_ticks(CLK_HZ, RELEASE_MS);
  localparam int DEB_W = $clog2(DEB_T + 1);
  localparam int REL_W = $clog2(REL_T + 1);
  // The event register is loaded on the edge where deb becomes DEB_T-1,
  // so the pulse is visible in the cycle deb reaches DEB_T-1.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_T - 2);
  localparam logic [REL_W-1:0] REL_INIT = REL_W'(REL_T);

  kp_state_e        state_r;
  kp_state_e        state_nxt_s;
  logic [REL_W-1:0] rel_r;
  logic [DEB_W-1:0] deb_r;
  logic [3:0]       cand_r;
  logic             released_s;
  logic             event_s;
  logic             key_event_r;
  logic [3:0]       key_code_r;

  assign released_s = (rel_r == '0);

  // Release timer: reloads on every pressed sample, counts down otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_r <= '0;
    end else if (kp_pressed) begin
      rel_r <= REL_INIT;
    end else if (!released_s) begin
      rel_r <= rel_r - REL_W'(1);
    end else begin
      rel_r <= rel_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (kp_pressed) state_nxt_s = ST_DEBOUNCE;
        else            state_nxt_s = ST_IDLE;
      end
      ST_DEBOUNCE: begin
        if (released_s)   state_nxt_s = ST_IDLE;
        else if (event_s) state_nxt_s = ST_HELD;
        else              state_nxt_s = ST_DEBOUNCE;
      end
      ST_HELD: begin
        if (released_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_HELD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode: the candidate has been stable for the full debounce time.
  always_comb begin
    event_s = 1'b0;
    if ((state_r == ST_DEBOUNCE) && !released_s && kp_pressed &&
        (kp_key == cand_r) && (deb_r == DEB_LAST)) begin
      event_s = 1'b1;
    end else begin
      event_s = 1'b0;
    end
  end

  // Candidate code and debounce counter; the counter only advances on matching
  // pressed samples, so a press shorter than the debounce time never fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_r <= 4'h0;
      deb_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (kp_pressed) begin
            cand_r <= kp_key;
            deb_r  <= '0;
          end
        end
        ST_DEBOUNCE: begin
          if (!released_s && kp_pressed) begin
            if (kp_key != cand_r) begin
              cand_r <= kp_key;
              deb_r  <= '0;
            end else begin
              deb_r <= deb_r + DEB_W'(1);
            end
          end
        end
        default: begin
          cand_r <= cand_r;
          deb_r  <= deb_r;
        end
      endcase
    end
  end

  // Registered event pulse and last accepted code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_event_r <= 1'b0;
      key_code_r  <= 4'h0;
    end else begin
      key_event_r <= event_s;
      if (event_s) key_code_r <= cand_r;
    end
  end

  assign key_event = key_event_r;
  assign key_code  = key_code_r;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounced key events feed a BCD entry buffer whose
// committed contents are handed downstream over a valid/ready handshake.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int RELEASE_MS  = 10,
  parameter int DIGITS      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            kp_key,
  input  logic                  kp_pressed,
  output logic                  key_event,
  output logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   disp_value,
  output logic [2:0]            disp_count,
  output logic                  entry_valid,
  output logic [4*DIGITS-1:0]   entry_value,
  output logic [2:0]            entry_count,
  input  logic                  entry_ready
);

  logic                ev_s;
  logic [3:0]          code_s;
  logic                commit_s;
  logic [4*DIGITS-1:0] disp_value_r;
  logic [2:0]          disp_count_r;
  logic                entry_valid_r;
  logic [4*DIGITS-1:0] entry_value_r;
  logic [2:0]          entry_count_r;

  keypad_debounce #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .RELEASE_MS  (RELEASE_MS)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .kp_key     (kp_key),
    .kp_pressed (kp_pressed),
    .key_event  (ev_s),
    .key_code   (code_s)
  );

  // Commit uses the registered valid, so a handshake in the same cycle still blocks it.
  always_comb begin
    commit_s = 1'b0;
    if (ev_s && (code_s == KEY_E) && (disp_count_r != 3'd0) && !entry_valid_r) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Live entry buffer: append digits, clear on F or on a successful commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_value_r <= '0;
      disp_count_r <= 3'd0;
    end else if (ev_s) begin
      if (code_s <= KEY_9) begin
        if (disp_count_r < 3'(DIGITS)) begin
          disp_value_r <= {disp_value_r[4*DIGITS-5:0], code_s};
          disp_count_r <= disp_count_r + 3'd1;
        end
      end else if ((code_s == KEY_F) || commit_s) begin
        disp_value_r <= '0;
        disp_count_r <= 3'd0;
      end
    end
  end

  // Committed entry and its handshake; data holds until valid && ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_valid_r <= 1'b0;
      entry_value_r <= '0;
      entry_count_r <= 3'd0;
    end else if (commit_s) begin
      entry_valid_r <= 1'b1;
      entry_value_r <= disp_value_r;
      entry_count_r <= disp_count_r;
    end else if (entry_valid_r && entry_ready) begin
      entry_valid_r <= 1'b0;
    end
  end

  assign key_event   = ev_s;
  assign key_code    = code_s;
  assign disp_value  = disp_value_r;
  assign disp_count  = disp_count_r;
  assign entry_valid = entry_valid_r;
  assign entry_value = entry_value_r;
  assign entry_count = entry_count_r;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl at CLK_HZ=10_000 (DEB_T=20, REL_T=10).
module tb_keypad_entry_ctrl;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  kp_key;
  logic        kp_pressed;
  logic        key_event;
  logic [3:0]  key_code;
  logic [15:0] disp_value;
  logic [2:0]  disp_count;
  logic        entry_valid;
  logic [15:0] entry_value;
  logic [2:0]  entry_count;
  logic        entry_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ev_cnt = 0;
  int ev_cyc = 0;
  int ev_base;
  int sw_cyc;

  keypad_entry_ctrl #(
    .CLK_HZ      (10_000),
    .DEBOUNCE_MS (2),
    .RELEASE_MS  (1),
    .DIGITS      (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .kp_key      (kp_key),
    .kp_pressed  (kp_pressed),
    .key_event   (key_event),
    .key_code    (key_code),
    .disp_value  (disp_value),
    .disp_count  (disp_count),
    .entry_valid (entry_valid),
    .entry_value (entry_value),
    .entry_count (entry_count),
    .entry_ready (entry_ready)
  );

  always #5 clk = ~clk;

  // Cycle counter and key_event monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (key_event === 1'b1) begin
      ev_cnt <= ev_cnt + 1;
      ev_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full press: held long enough to debounce, then released long enough to clear.
  task automatic press(input logic [3:0] code);
    kp_key     = code;
    kp_pressed = 1'b1;
    repeat (25) tick();
    kp_pressed = 1'b0;
    repeat (15) tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    kp_key      = 4'h0;
    kp_pressed  = 1'b0;
    entry_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_key_event",   32'(key_event),   32'd0);
    chk("rst_key_code",    32'(key_code),    32'd0);
    chk("rst_disp_value",  32'(disp_value),  32'd0);
    chk("rst_disp_count",  32'(disp_count),  32'd0);
    chk("rst_entry_valid", 32'(entry_valid), 32'd0);
    chk("rst_entry_value", 32'(entry_value), 32'd0);
    chk("rst_entry_count", 32'(entry_count), 32'd0);

    // Key 5 with kp_pressed high 3 of every 4 cycles.
    ev_base = ev_cnt;
    for (int i = 0; i < 100; i++) begin
      kp_pressed = ((i % 4) != 3);
      kp_key     = ((i % 4) != 3) ? 4'h5 : 4'h0;
      tick();
    end
    kp_pressed = 1'b0;
    repeat (15) tick();
    chk("k5_events",     32'(ev_cnt - ev_base), 32'd1);
    chk("k5_key_code",   32'(key_code),         32'd5);
    chk("k5_disp_value", 32'(disp_value),       32'h0005);
    chk("k5_disp_count", 32'(disp_count),       32'd1);
    press(KEY_F);
    chk("clr_disp_count", 32'(disp_count), 32'd0);

    // Bounce: 3 for 8 cycles, then 7 for 30 cycles.
    ev_base    = ev_cnt;
    kp_key     = 4'h3;
    kp_pressed = 1'b1;
    repeat (8) tick();
    kp_key = 4'h7;
    sw_cyc = cyc;
    repeat (30) tick();
    kp_pressed = 1'b0;
    repeat (15) tick();
    chk("bnc_events",    32'(ev_cnt - ev_base), 32'd1);
    chk("bnc_key_code",  32'(key_code),         32'd7);
    chk("bnc_latency",   32'(ev_cyc - sw_cyc),  32'd20);
    chk("bnc_disp",      32'(disp_value),       32'h0007);
    press(KEY_F);

    // Short press: 15 cycles of code 2, then released.
    ev_base    = ev_cnt;
    kp_key     = 4'h2;
    kp_pressed = 1'b1;
    repeat (15) tick();
    kp_pressed = 1'b0;
    repeat (7) tick();
    chk("short_not_idle_yet", 32'(dut.u_debounce.state_r != ST_IDLE), 32'd1);
    repeat (4) tick();
    chk("short_idle",   32'(dut.u_debounce.state_r), 32'(ST_IDLE));
    chk("short_events", 32'(ev_cnt - ev_base),       32'd0);

    // 1,2,3,4,9 then E with ready low: 9 dropped, entry committed.
    press(KEY_1);
    press(KEY_2);
    press(KEY_3);
    press(KEY_4);
    press(KEY_9);
    chk("full_disp", 32'(disp_value), 32'h1234);
    press(KEY_E);
    chk("cm_valid",      32'(entry_valid), 32'd1);
    chk("cm_value",      32'(entry_value), 32'h1234);
    chk("cm_count",      32'(entry_count), 32'd4);
    chk("cm_disp_count", 32'(disp_count),  32'd0);
    press(KEY_7);
    press(KEY_E);
    chk("pend_disp_value", 32'(disp_value),  32'h0007);
    chk("pend_disp_count", 32'(disp_count),  32'd1);
    chk("pend_value",      32'(entry_value), 32'h1234);
    chk("pend_valid",      32'(entry_valid), 32'd1);
    entry_ready = 1'b1;
    tick();
    chk("hs_valid_low", 32'(entry_valid), 32'd0);
    repeat (3) tick();
    entry_ready = 1'b0;
    press(KEY_F);

    // 8,6, A ignored, F clears, E on empty does nothing.
    press(KEY_8);
    press(KEY_6);
    chk("d86_disp", 32'(disp_value), 32'h0086);
    press(KEY_A);
    chk("a_disp",  32'(disp_value), 32'h0086);
    chk("a_count", 32'(disp_count), 32'd2);
    press(KEY_F);
    chk("f_count", 32'(disp_count), 32'd0);
    chk("f_disp",  32'(disp_value), 32'h0000);
    press(KEY_E);
    chk("e_empty_valid", 32'(entry_valid), 32'd0);

    // Reset with an entry pending and a key mid-debounce.
    press(KEY_5);
    press(KEY_E);
    chk("pre_rst_valid", 32'(entry_valid), 32'd1);
    ev_base    = ev_cnt;
    kp_key     = 4'h3;
    kp_pressed = 1'b1;
    repeat (10) tick();
    chk("pre_rst_state", 32'(dut.u_debounce.state_r), 32'(ST_DEBOUNCE));
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(entry_valid), 32'd0);
    chk("arst_value", 32'(entry_value), 32'd0);
    chk("arst_code",  32'(key_code),    32'd0);
    chk("arst_count", 32'(disp_count),  32'd0);
    chk("arst_state", 32'(dut.u_debounce.state_r), 32'(ST_IDLE));
    kp_pressed = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("post_rst_events", 32'(ev_cnt - ev_base), 32'd0);
    chk("post_rst_valid",  32'(entry_valid),      32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
